// File: rtl/sub16_pipe.sv
// -----------------------------------------------------------------------------
// sub16_pipe
//   Four-stage pipelined 16-bit subtractor with valid/ready handshakes on both
//   sides. D = A - B - bin (mod 2^16) is computed as A + ~B + ~bin, one 4-bit
//   carry-lookahead nibble per stage, with the carry passed between stages in
//   registers. S4 is the output register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers {A, B, bin}
//   in_ready   block accepts the operand set on this cycle
//   A, B       16-bit minuend / subtrahend
//   bin        borrow-in
//   out_valid  S4 holds a valid result
//   out_ready  downstream consumes the result
//   D          difference
//   bout       borrow-out (unsigned A < B + bin)
//   ovf        signed overflow
//   zero       D == 0
// -----------------------------------------------------------------------------
module sub16_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] D,
    output logic        bout,
    output logic        ovf,
    output logic        zero
);

    // 4-bit carry-lookahead adder; returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b_n,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b_n;
        p    = a ^ b_n;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Stage registers: each stage keeps only the operand nibbles still to be
    // summed, the difference nibbles already produced, and the running carry.
    logic        s1_v_q, s1_v_d, s1_c_q, s1_c_d;
    logic [3:0]  s1_d_q, s1_d_d;
    logic [11:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

    logic        s2_v_q, s2_v_d, s2_c_q, s2_c_d;
    logic [7:0]  s2_d_q, s2_d_d;
    logic [7:0]  s2_a_q, s2_a_d, s2_b_q, s2_b_d;

    logic        s3_v_q, s3_v_d, s3_c_q, s3_c_d;
    logic [11:0] s3_d_q, s3_d_d;
    logic [3:0]  s3_a_q, s3_a_d, s3_b_q, s3_b_d;

    logic        s4_v_q, s4_v_d;
    logic [15:0] s4_d_q, s4_d_d;
    logic        s4_bout_q, s4_bout_d, s4_ovf_q, s4_ovf_d, s4_zero_q, s4_zero_d;

    // Per-stage nibble results.
    logic [4:0]  nib0, nib1, nib2, nib3;
    logic [15:0] d_full;

    assign nib0   = cla4(A[3:0],  ~B[3:0],  ~bin);
    assign nib1   = cla4(s1_a_q[3:0], ~s1_b_q[3:0], s1_c_q);
    assign nib2   = cla4(s2_a_q[3:0], ~s2_b_q[3:0], s2_c_q);
    assign nib3   = cla4(s3_a_q,      ~s3_b_q,      s3_c_q);
    assign d_full = {nib3[3:0], s3_d_q};

    // Handshake: a stage advances when it holds data and the stage after it is
    // empty or advancing on the same edge. The chain starts at the output.
    logic adv1, adv2, adv3, adv4, in_fire;

    assign adv4     = s4_v_q & out_ready;
    assign adv3     = s3_v_q & (~s4_v_q | adv4);
    assign adv2     = s2_v_q & (~s3_v_q | adv3);
    assign adv1     = s1_v_q & (~s2_v_q | adv2);
    assign in_ready = ~s1_v_q | adv1;
    assign in_fire  = in_valid & in_ready;

    // NOTE: every *_d gets its hold value first so no path leaves a latch.
    always_comb begin
        s1_v_d = in_fire | (s1_v_q & ~adv1);
        s1_c_d = s1_c_q;  s1_d_d = s1_d_q;  s1_a_d = s1_a_q;  s1_b_d = s1_b_q;
        s2_v_d = adv1 | (s2_v_q & ~adv2);
        s2_c_d = s2_c_q;  s2_d_d = s2_d_q;  s2_a_d = s2_a_q;  s2_b_d = s2_b_q;
        s3_v_d = adv2 | (s3_v_q & ~adv3);
        s3_c_d = s3_c_q;  s3_d_d = s3_d_q;  s3_a_d = s3_a_q;  s3_b_d = s3_b_q;
        s4_v_d    = adv3 | (s4_v_q & ~adv4);
        s4_d_d    = s4_d_q;
        s4_bout_d = s4_bout_q;
        s4_ovf_d  = s4_ovf_q;
        s4_zero_d = s4_zero_q;

        if (in_fire) begin
            s1_c_d = nib0[4];
            s1_d_d = nib0[3:0];
            s1_a_d = A[15:4];
            s1_b_d = B[15:4];
        end
        if (adv1) begin
            s2_c_d = nib1[4];
            s2_d_d = {nib1[3:0], s1_d_q};
            s2_a_d = s1_a_q[11:4];
            s2_b_d = s1_b_q[11:4];
        end
        if (adv2) begin
            s3_c_d = nib2[4];
            s3_d_d = {nib2[3:0], s2_d_q};
            s3_a_d = s2_a_q[7:4];
            s3_b_d = s2_b_q[7:4];
        end
        if (adv3) begin
            // Borrow is the inverted carry; overflow compares operand and
            // result sign bits (s3_a_q[3] / s3_b_q[3] are A[15] / B[15]).
            s4_d_d    = d_full;
            s4_bout_d = ~nib3[4];
            s4_ovf_d  = (s3_a_q[3] != s3_b_q[3]) && (nib3[3] != s3_a_q[3]);
            s4_zero_d = (d_full == 16'h0000);
        end
    end

    // NOTE: the whole datapath is reset (not just valids) so the outputs read
    // as zero during reset; sequential state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;  s1_c_q <= 1'b0;  s1_d_q <= '0;  s1_a_q <= '0;  s1_b_q <= '0;
            s2_v_q <= 1'b0;  s2_c_q <= 1'b0;  s2_d_q <= '0;  s2_a_q <= '0;  s2_b_q <= '0;
            s3_v_q <= 1'b0;  s3_c_q <= 1'b0;  s3_d_q <= '0;  s3_a_q <= '0;  s3_b_q <= '0;
            s4_v_q    <= 1'b0;
            s4_d_q    <= '0;
            s4_bout_q <= 1'b0;
            s4_ovf_q  <= 1'b0;
            s4_zero_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;  s1_c_q <= s1_c_d;  s1_d_q <= s1_d_d;  s1_a_q <= s1_a_d;  s1_b_q <= s1_b_d;
            s2_v_q <= s2_v_d;  s2_c_q <= s2_c_d;  s2_d_q <= s2_d_d;  s2_a_q <= s2_a_d;  s2_b_q <= s2_b_d;
            s3_v_q <= s3_v_d;  s3_c_q <= s3_c_d;  s3_d_q <= s3_d_d;  s3_a_q <= s3_a_d;  s3_b_q <= s3_b_d;
            s4_v_q    <= s4_v_d;
            s4_d_q    <= s4_d_d;
            s4_bout_q <= s4_bout_d;
            s4_ovf_q  <= s4_ovf_d;
            s4_zero_q <= s4_zero_d;
        end
    end

    assign out_valid = s4_v_q;
    assign D         = s4_d_q;
    assign bout      = s4_bout_q;
    assign ovf       = s4_ovf_q;
    assign zero      = s4_zero_q;

endmodule

// File: tb/tb_sub16_pipe.sv
// -----------------------------------------------------------------------------
// tb_sub16_pipe
//   Directed and randomized self-checking bench for sub16_pipe. Expected values
//   come from hand-computed constants and a behavioural subtraction model.
// -----------------------------------------------------------------------------
module tb_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        bout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    sub16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: {bout, ovf, zero, D}.
    function automatic logic [18:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] r;
        logic        v;
        r = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        v = (a[15] != b[15]) && (r[15] != a[15]);
        return {r[16], v, (r[15:0] == 16'h0000), r[15:0]};
    endfunction

    function automatic logic [15:0] bp_a(input int i);
        return 16'(16'h0111 * (i + 1));
    endfunction

    function automatic logic [15:0] bp_b(input int i);
        return 16'(i * 3);
    endfunction

    // One isolated operand set; called at 1 time unit after a rising edge with
    // the pipeline empty. Checks latency, result flags and the drain.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                           input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
        A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = 16'hFFFF; B = 16'h0000; bin = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_not_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_D"}, 32'(D), 32'(ed));
        chk({tag, "_flags"}, 32'({bout, ovf, zero}), 32'({eb, eo, ez}));
        @(posedge clk);
        #1;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin : main
        int          idx;
        int          got;
        int          first_c;
        int          last_c;
        int          seen;
        logic        fire;
        logic [18:0] sb[$];
        logic [18:0] exp_v;
        logic [15:0] ra, rb;
        logic        rbi;
        logic        have_pend;
        int          sent;
        int          rcvd;
        int          cyc;
        localparam int NRAND = 10000;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'h0; B = 16'h0; bin = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_flags", 32'({bout, ovf, zero}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic vectors.
        run_one("basic",    16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_one("underflow",16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_one("sovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_one("bin_zero", 16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_one("wrap_zero",16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("neg_ovf",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Backpressure: six sets offered with out_ready low.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 6) begin
                in_valid = 1'b1; A = bp_a(idx); B = bp_b(idx); bin = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        A = bp_a(idx); B = bp_b(idx); bin = idx[0]; in_valid = 1'b1;
        #1;
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        exp_v = ref_sub(bp_a(0), bp_b(0), 1'b0);
        chk("bp_hold_D", 32'(D), 32'(exp_v[15:0]));
        @(posedge clk);
        #1;
        chk("bp_hold_D_again", 32'(D), 32'(exp_v[15:0]));
        chk("bp_hold_flags", 32'({bout, ovf, zero}), 32'(exp_v[18:16]));

        out_ready = 1'b1;
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 12; c++) begin
            if (idx < 6) begin
                in_valid = 1'b1; A = bp_a(idx); B = bp_b(idx); bin = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (got < 6) begin
                    exp_v = ref_sub(bp_a(got), bp_b(got), got[0]);
                    chk("bp_stream_result", 32'({exp_v[18:16], D}), 32'(exp_v));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        chk("bp_result_count", 32'(got), 32'd6);
        chk("bp_input_count", 32'(idx), 32'd6);
        chk("bp_no_gaps", 32'(last_c - first_c), 32'd5);

        // Random valid/ready stalls against the model and a scoreboard.
        sent = 0; rcvd = 0; cyc = 0; have_pend = 1'b0;
        ra = 16'h0; rb = 16'h0; rbi = 1'b0;
        while ((sent < NRAND || rcvd < sent) && cyc < 60000) begin
            if (!have_pend && sent < NRAND) begin
                ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom_range(0, 1));
                have_pend = 1'b1;
            end
            in_valid  = have_pend && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = in_valid ? ra : 16'($urandom);
            B = in_valid ? rb : 16'($urandom);
            bin = in_valid ? rbi : 1'($urandom_range(0, 1));
            #1;
            fire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL rand_spurious observed=out_valid expected=no_result_pending");
                end
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    chk("rand_result", 32'({bout, ovf, zero, D}), 32'(exp_v));
                end
                rcvd++;
            end
            @(posedge clk);
            #1;
            if (fire) begin
                sb.push_back(ref_sub(ra, rb, rbi));
                sent++;
                have_pend = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_timeout", 32'(cyc < 60000), 32'd1);
        chk("rand_sent", 32'(sent), 32'(NRAND));
        chk("rand_count_equal", 32'(rcvd), 32'(sent));

        // Reset with three sets in flight.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; A = 16'h4000 + 16'(i); B = 16'h0001; bin = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_D", 32'(D), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_stale", 32'(seen), 32'd0);
        run_one("post_rst", 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
